uart_rx_frame_ctrl: RTL and testbench

- UART receive frame controller; sits directly downstream of the RX edge/bit counter stage.
- Consumes the counter's oversampling phase (`edge_cnt`) and drives the counter's `enable`.
- Majority-votes three oversamples per bit, walks the frame (start, 8 data bits LSB first, optional parity, stop), and presents the deserialized byte with a one-cycle `data_valid` pulse, or flags a parity/stop error.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_frame_ctrl_if.sv | 30 +++
 rtl/rx_data_sampler.sv | 54 +++++
 rtl/uart_rx_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART RX frame controller
// Purpose: frame FSM state encoding, parity type codes, legal oversampling
//          ratios and the 2-of-3 majority helper.
// Ports:   none (package).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - serial line, counter handshake and byte result bundle
// Purpose: groups every non-clock/reset signal of uart_rx_frame_ctrl.
// Ports (master drives line/config/counter phase, slave drives results):
//   rx_in, prescale, par_en, par_typ, edge_cnt  -> slave
//   enable, p_data, data_valid, par_err, stp_err -> master
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
);
  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               par_typ;
  logic [PRESC_W-1:0] edge_cnt;
  logic               enable;
  logic [DATA_W-1:0]  p_data;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;

  modport master (
    output rx_in, prescale, par_en, par_typ, edge_cnt,
    input  enable, p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ, edge_cnt,
    output enable, p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/rx_data_sampler.sv
// rtl/rx_data_sampler.sv - three-tap mid-bit capture with majority vote
// Purpose: captures rx_in at edge_cnt == h-1, h, h+1 (h = prescale>>1) and
//          reports the 2-of-3 majority the cycle after the last tap.
// Ports:   clck, rst (async active-low), rx_in, prescale, edge_cnt,
//          sample_en -> sampled_bit, sample_done (1-cycle pulse).
module rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clck,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic               sample_en,
  output logic               sampled_bit,
  output logic               sample_done
);

  logic [PRESC_W-1:0] half;
  logic [2:0]         taps_q, taps_d;
  logic               done_q, done_d;

  assign half = prescale >> 1;

  always_comb begin
    taps_d = taps_q;
    done_d = 1'b0;
    if (sample_en) begin
      if (edge_cnt == half - PRESC_W'(1)) taps_d[0] = rx_in;
      if (edge_cnt == half)               taps_d[1] = rx_in;
      if (edge_cnt == half + PRESC_W'(1)) begin
        taps_d[2] = rx_in;
        done_d    = 1'b1;
      end
    end
  end

  // Taps reset to the idle line level so a stale vote never reads as a start bit.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      taps_q <= 3'b111;
      done_q <= 1'b0;
    end else begin
      taps_q <= taps_d;
      done_q <= done_d;
    end
  end

  assign sampled_bit = maj3(taps_q[0], taps_q[1], taps_q[2]);
  assign sample_done = done_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame FSM, deserializer and error checks
// Purpose: walks start / DATA_W data bits (LSB first) / optional parity / stop,
//          delivers error-free bytes with a 1-cycle data_valid pulse and
//          flags parity and stop errors.
// Ports:   clck, rst (async active-low), bus (uart_rx_frame_ctrl_if.slave).
// Option:  RX_SYNC_EN - route rx_in through a 2-flop synchronizer (reset 1).
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input logic                 clck,
  input logic                 rst,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], bus.rx_in};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = bus.rx_in;
`endif

  rx_state_e          state_q, state_d;
  logic               enable_q, enable_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  p_data_q, p_data_d;
  logic               data_valid_q, data_valid_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic               stop_chk_q, stop_chk_d;

  logic sampled_bit, sample_done, bit_end;

  rx_data_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clck        (clck),
    .rst         (rst),
    .rx_in       (rx_s),
    .prescale    (bus.prescale),
    .edge_cnt    (bus.edge_cnt),
    .sample_en   (enable_q),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  assign bit_end = (bus.edge_cnt == bus.prescale);

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stop_chk_d   = stop_chk_q;
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (!rx_s) begin
          state_d    = START;
          enable_d   = 1'b1;
          par_en_d   = bus.par_en;
          par_typ_d  = bus.par_typ;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
          stop_chk_d = 1'b0;
          idx_d      = '0;
        end
      end
      START: begin
        // A high mid-bit vote means the falling edge was noise, not a start bit.
        if (sample_done && sampled_bit) begin
          state_d  = IDLE;
          enable_d = 1'b0;
        end else if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (sample_done) shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP;
          else                             idx_d   = idx_q + IDX_W'(1);
        end
      end
      PARITY: begin
        if (sample_done)
          par_err_d = sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Leave right after the stop vote so a back-to-back start edge is not missed.
        if (stop_chk_q) begin
          stop_chk_d = 1'b0;
          if (!par_err_q && !stp_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          state_d  = IDLE;
          enable_d = 1'b0;
        end else if (sample_done) begin
          stp_err_d  = ~sampled_bit;
          stop_chk_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      shift_q      <= '0;
      idx_q        <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stop_chk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      stop_chk_q   <= stop_chk_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl dut (
    .clck (clk),
    .rst  (rst_n),
    .bus  (bus)
  );

  // Upstream edge counter: held at 0 while disabled, then counts 1..prescale.
  logic [5:0] cnt_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (!bus.enable)         cnt_q <= '0;
    else if (cnt_q == bus.prescale) cnt_q <= 6'd1;
    else                          cnt_q <= cnt_q + 6'd1;
  end
  assign bus.edge_cnt = cnt_q;

  typedef struct {
    logic       dv;
    logic [7:0] data;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int presc  = 8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic dv, input logic [7:0] d, input logic pe, input logic se);
    exp_t e;
    e.dv = dv; e.data = d; e.pe = pe; e.se = se;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit cell of presc cycles; noise flips the cycle holding the middle tap.
  task automatic drive_bit(input logic v, input bit noise);
    for (int j = 0; j < presc; j++) begin
      bus.rx_in = (noise && j == presc / 2 + 1) ? ~v : v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input logic par_bit,
                            input logic stop_bit, input int noise_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], noise_bit == i);
    if (pe) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
    bus.rx_in = 1'b1;
  endtask

  // Monitor: each frame ends with enable falling; compare the result then.
  initial begin
    logic prev_en;
    logic prev_dv;
    exp_t e;
    prev_en = 1'b0;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
        prev_dv = 1'b0;
      end else begin
        if (bus.data_valid) check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
        if (prev_en && !bus.enable) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame_end", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("data_valid", {31'd0, bus.data_valid}, {31'd0, e.dv});
            check("p_data", {24'd0, bus.p_data}, {24'd0, e.data});
            check("par_err", {31'd0, bus.par_err}, {31'd0, e.pe});
            check("stp_err", {31'd0, bus.stp_err}, {31'd0, e.se});
          end
        end
        prev_en = bus.enable;
        prev_dv = bus.data_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int waited;
    bus.rx_in    = 1'b1;
    bus.prescale = 6'(PRESC_8);
    bus.par_en   = 1'b0;
    bus.par_typ  = PAR_EVEN;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    check("rst_enable", {31'd0, bus.enable}, 32'd0);
    check("rst_p_data", {24'd0, bus.p_data}, 32'd0);
    check("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_par_err", {31'd0, bus.par_err}, 32'd0);
    check("rst_stp_err", {31'd0, bus.stp_err}, 32'd0);

    // Basic frame, no parity
    presc = PRESC_8; bus.prescale = 6'(PRESC_8); bus.par_en = 1'b0;
    push(1'b1, 8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    idle(3 * presc);
    check("enable_after_basic", {31'd0, bus.enable}, 32'd0);

    // Even parity, correct parity bit (0x3C has four ones)
    presc = PRESC_16; bus.prescale = 6'(PRESC_16); bus.par_en = 1'b1;
    push(1'b1, 8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    idle(3 * presc);

    // Wrong parity bit: flagged, byte not delivered
    push(1'b0, 8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    idle(3 * presc);

    // Stop bit low
    presc = PRESC_8; bus.prescale = 6'(PRESC_8); bus.par_en = 1'b0;
    push(1'b0, 8'h3C, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1);
    idle(3 * presc);

    // Two-cycle glitch: rejected in START, flags cleared
    push(1'b0, 8'h3C, 1'b0, 1'b0);
    bus.rx_in = 1'b0;
    idle(2);
    bus.rx_in = 1'b1;
    idle(3 * presc);
    check("enable_after_glitch", {31'd0, bus.enable}, 32'd0);

    // Middle-tap inversion on data bit 3 is outvoted
    push(1'b1, 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 3);
    idle(3 * presc);

    // Reset during data bit 4
    d = 8'h77;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    bus.rx_in = d[4];
    idle(2);
    check("enable_before_reset", {31'd0, bus.enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_enable", {31'd0, bus.enable}, 32'd0);
    check("midrst_p_data", {24'd0, bus.p_data}, 32'd0);
    check("midrst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("midrst_par_err", {31'd0, bus.par_err}, 32'd0);
    check("midrst_stp_err", {31'd0, bus.stp_err}, 32'd0);
    bus.rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Back-to-back frames
    push(1'b1, 8'h01, 1'b0, 1'b0);
    push(1'b1, 8'hFE, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, -1);
    idle(4 * presc);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      idle(1);
      waited++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
